apb_gpio_master_arb: RTL and testbench
======================================

Name: apb_gpio_master_arb

Overview:
- Two-requester APB master that shares one APB segment and its GPIO slave between two on-chip requesters, e.g. a CPU port and a DMA/test port.
- Arbitrates round-robin between the requesters.
- Sequences the APB SETUP/ACCESS phases and waits for PREADY.
- Returns read data and completion or timeout status to the requester that owns the grant.
- Sits between the requesters and the gpio slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY pins.

Parameters:
- PDATA_SIZE, 32, width of address and data paths (multiple of 8).
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for PREADY before aborting (≥2).

Ports:
- PCLK  in  1  system clock; all state updates on rising edge.
- PRESET  in  1  synchronous active-high reset.
- REQ  in  2  bit i = requester i wants a transfer; held until DONE[i].
- REQ_WRITE  in  2  bit i: 1=write, 0=read.
- REQ_ADDR  in  2*PDATA_SIZE  requester i address in slice [i*PDATA_SIZE +: PDATA_SIZE].
- REQ_WDATA  in  2*PDATA_SIZE  requester i write data, same slicing.
- GRANT  out  2  one-hot owner of the current transfer; 0 when idle.
- DONE  out  2  one-cycle pulse to the owner on completion.
- ERR  out  1  valid with DONE; 1 = timeout abort.
- RDATA  out  PDATA_SIZE  read data; valid with DONE for reads, held until next DONE.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  PDATA_SIZE  APB address.
- PWDATA  out  PDATA_SIZE  APB write data.
- PRDATA  in  PDATA_SIZE  APB read data from slave.
- PREADY  in  1  APB ready from slave.

Behaviour:
- All outputs are registered.
- Reset values: GRANT=0, DONE=0, ERR=0, RDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. State=IDLE, timeout counter=0, last-grant pointer=1, so requester 0 wins first.
- States: IDLE, SETUP, ACCESS.

IDLE:
- If REQ≠0, select the winner and go to SETUP at the same edge.
- On that edge: set GRANT, PSEL=1, PENABLE=0, and latch PWRITE/PADDR/PWDATA from the winner's slices.
- The winner is the only requester asserting REQ, or, if both assert, the one not equal to the last-grant pointer.
- Update the last-grant pointer on grant.

SETUP:
- Always exactly one cycle.
- Next edge goes to ACCESS with PENABLE=1 and counter cleared.

ACCESS:
- PREADY is sampled each edge.
- If PREADY=1:
  - Pulse DONE[owner]=1 and ERR=0.
  - If PWRITE=0, RDATA<=PRDATA; otherwise RDATA is unchanged.
  - Set PSEL=0, PENABLE=0, GRANT=0; go to IDLE.
- Else the counter increments. When the counter reaches TIMEOUT-1 without PREADY:
  - Pulse DONE[owner]=1 and ERR=1; RDATA<=0.
  - Release the bus; go to IDLE.

Timing and ordering rules:
- PREADY is ignored in IDLE and SETUP, so a stale PREADY from the previous transfer has no effect.
- Every transfer is followed by at least one IDLE cycle; there is no back-to-back SETUP.
- Minimum transfer: IDLE-edge grant, SETUP, one ACCESS. DONE pulses on the 3rd rising edge after REQ is sampled high.
- PADDR/PWDATA/PWRITE stay stable from SETUP through the end of ACCESS. Requester inputs are ignored after latch.
- REQ deasserted mid-transfer: the transfer still completes and DONE is still pulsed.
- A requester that holds REQ after DONE is treated as a new request. Round-robin therefore alternates when both hold REQ continuously.
- PRESET mid-transfer: immediate return to reset values at the next edge. No DONE is generated. The pointer returns to 1.
- DONE and GRANT are never asserted for both requesters at once.

Test Plan:
- Single write: REQ=01, write, addr=1, wdata=0x0000_00FF; PREADY=1 on 1st ACCESS cycle → PSEL/PADDR=1/PWDATA=0xFF seen in SETUP, PENABLE on the next cycle, DONE=01 with ERR=0 three edges after REQ.
- Read: requester 1 reads addr=0; slave returns PRDATA=0xA5A5_0003 with PREADY on the 2nd ACCESS cycle → RDATA=0xA5A5_0003 with DONE=10; RDATA holds afterwards.
- Contention: REQ=11 held for 4 transfers → grant order 0,1,0,1; each separated by ≥1 IDLE cycle; GRANT always one-hot.
- Timeout: PREADY tied 0, TIMEOUT=16 → exactly 16 ACCESS cycles, then DONE with ERR=1, RDATA=0, PSEL=0 on the next cycle.
- Reset mid-ACCESS: assert PRESET for 1 cycle during ACCESS → all outputs 0 next edge, no DONE; a subsequent REQ=11 is granted to requester 0 first.
- Stale PREADY: PREADY held 1 continuously → each transfer still spends exactly one SETUP cycle with PENABLE=0 before completing.

Source files
------------

// File: rtl/apb_gpio_master_arb.sv
// Two-requester round-robin APB master for a shared GPIO slave segment.
// Sequences SETUP/ACCESS, waits for PREADY with a bounded timeout, and returns status to the owner.
module apb_gpio_master_arb #(
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              REQ,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*PDATA_SIZE-1:0] REQ_ADDR,
  input  logic [2*PDATA_SIZE-1:0] REQ_WDATA,
  output logic [1:0]              GRANT,
  output logic [1:0]              DONE,
  output logic                    ERR,
  output logic [PDATA_SIZE-1:0]   RDATA,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PDATA_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  r_last, w_last;
  logic [1:0]            r_grant, w_grant;
  logic [1:0]            r_done, w_done;
  logic                  r_err, w_err;
  logic [PDATA_SIZE-1:0] r_rdata, w_rdata;
  logic                  r_psel, w_psel;
  logic                  r_penable, w_penable;
  logic                  r_pwrite, w_pwrite;
  logic [PDATA_SIZE-1:0] r_paddr, w_paddr;
  logic [PDATA_SIZE-1:0] r_pwdata, w_pwdata;
  logic                  w_win;
  logic                  w_timeout;

  // Contention goes to whoever was not granted last; a lone requester wins outright.
  assign w_win     = (REQ == 2'b11) ? ~r_last : REQ[1];
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_grant   <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt;
      r_last    <= w_last;
      r_grant   <= w_grant;
      r_done    <= w_done;
      r_err     <= w_err;
      r_rdata   <= w_rdata;
      r_psel    <= w_psel;
      r_penable <= w_penable;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (|REQ) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (PREADY || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt     = r_cnt;
    w_last    = r_last;
    w_grant   = r_grant;
    w_done    = 2'b00;
    w_err     = 1'b0;
    w_rdata   = r_rdata;
    w_psel    = r_psel;
    w_penable = r_penable;
    w_pwrite  = r_pwrite;
    w_paddr   = r_paddr;
    w_pwdata  = r_pwdata;
    case (r_state)
      S_IDLE: begin
        if (|REQ) begin
          w_grant   = {w_win, ~w_win};
          w_last    = w_win;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_pwrite  = REQ_WRITE[w_win];
          w_paddr   = w_win ? REQ_ADDR[2*PDATA_SIZE-1:PDATA_SIZE]  : REQ_ADDR[PDATA_SIZE-1:0];
          w_pwdata  = w_win ? REQ_WDATA[2*PDATA_SIZE-1:PDATA_SIZE] : REQ_WDATA[PDATA_SIZE-1:0];
        end
      end
      S_SETUP: begin
        w_penable = 1'b1;
        w_cnt     = '0;
      end
      S_ACCESS: begin
        if (PREADY || w_timeout) begin
          w_done    = r_grant;
          w_err     = ~PREADY;
          w_psel    = 1'b0;
          w_penable = 1'b0;
          w_grant   = 2'b00;
          if (!PREADY)      w_rdata = '0;
          else if (!r_pwrite) w_rdata = PRDATA;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign GRANT   = r_grant;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign RDATA   = r_rdata;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
endmodule

// File: tb/tb_apb_gpio_master_arb.sv
// Directed bench for apb_gpio_master_arb: inputs driven 1ns after each rising edge, outputs checked there too.
module tb_apb_gpio_master_arb;
  localparam int P = 32;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [1:0]   REQ, REQ_WRITE;
  logic [2*P-1:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]   GRANT, DONE;
  logic         ERR, PSEL, PENABLE, PWRITE, PREADY;
  logic [P-1:0] RDATA, PADDR, PWDATA, PRDATA;

  int n_cmp = 0;
  int n_bad = 0;

  apb_gpio_master_arb #(.PDATA_SIZE(P), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .GRANT(GRANT), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; REQ = 2'b00; REQ_WRITE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
    PRDATA = 32'hFFFF_FFFF; PREADY = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({GRANT, DONE, ERR, PSEL, PENABLE, PWRITE} !== 8'b0 || RDATA !== 0 || PADDR !== 0 || PWDATA !== 0) begin
      n_bad++;
      $display("FAIL reset_values: got grant=%b done=%b err=%b psel=%b pen=%b pwr=%b rdata=%h paddr=%h pwdata=%h, want all zero",
               GRANT, DONE, ERR, PSEL, PENABLE, PWRITE, RDATA, PADDR, PWDATA);
    end
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    REQ = 2'b01; REQ_WRITE = 2'b01; REQ_ADDR = {32'h0, 32'h1}; REQ_WDATA = {32'h0, 32'hFF};
    PREADY = 1'b1;
    tick();
    n_cmp++;
    if ({GRANT, PSEL, PENABLE, PWRITE, DONE} !== 7'b01_1_0_1_00 || PADDR !== 32'h1 || PWDATA !== 32'hFF) begin
      n_bad++;
      $display("FAIL write_setup: got grant=%b psel=%b pen=%b pwr=%b done=%b paddr=%h pwdata=%h, want 01 1 0 1 00 1 ff",
               GRANT, PSEL, PENABLE, PWRITE, DONE, PADDR, PWDATA);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, DONE} !== 4'b1_1_00) begin
      n_bad++;
      $display("FAIL write_access: got psel=%b pen=%b done=%b, want 1 1 00", PSEL, PENABLE, DONE);
    end
    tick();
    n_cmp++;
    if ({DONE, ERR, PSEL, PENABLE, GRANT} !== 7'b01_0_0_0_00) begin
      n_bad++;
      $display("FAIL write_done: got done=%b err=%b psel=%b pen=%b grant=%b, want 01 0 0 0 00",
               DONE, ERR, PSEL, PENABLE, GRANT);
    end
    REQ = 2'b00; PREADY = 1'b0;
    tick();
    n_cmp++;
    if ({DONE, PSEL} !== 3'b00_0) begin
      n_bad++;
      $display("FAIL write_pulse_end: got done=%b psel=%b, want 00 0", DONE, PSEL);
    end
  endtask

  task automatic test_read();
    REQ = 2'b10; REQ_WRITE = 2'b00; REQ_ADDR = {32'h0, 32'h9}; PREADY = 1'b0; PRDATA = 32'h0;
    tick();
    n_cmp++;
    if ({GRANT, PSEL, PENABLE, PWRITE} !== 5'b10_1_0_0 || PADDR !== 32'h0) begin
      n_bad++;
      $display("FAIL read_setup: got grant=%b psel=%b pen=%b pwr=%b paddr=%h, want 10 1 0 0 0",
               GRANT, PSEL, PENABLE, PWRITE, PADDR);
    end
    tick();
    tick();
    n_cmp++;
    if ({DONE, PSEL, PENABLE} !== 4'b00_1_1) begin
      n_bad++;
      $display("FAIL read_wait: got done=%b psel=%b pen=%b, want 00 1 1", DONE, PSEL, PENABLE);
    end
    PREADY = 1'b1; PRDATA = 32'hA5A5_0003;
    tick();
    n_cmp++;
    if (DONE !== 2'b10 || ERR !== 1'b0 || RDATA !== 32'hA5A5_0003) begin
      n_bad++;
      $display("FAIL read_done: got done=%b err=%b rdata=%h, want 10 0 a5a50003", DONE, ERR, RDATA);
    end
    REQ = 2'b00; PREADY = 1'b0; PRDATA = 32'h0;
    tick(); tick();
    n_cmp++;
    if (RDATA !== 32'hA5A5_0003 || DONE !== 2'b00) begin
      n_bad++;
      $display("FAIL read_hold: got rdata=%h done=%b, want a5a50003 00", RDATA, DONE);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    REQ = 2'b11; REQ_WRITE = 2'b00; PREADY = 1'b1; PRDATA = 32'h1234_5678;
    for (int k = 0; k < 12; k++) begin
      exp = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_cmp++;
      case (k % 3)
        0: if ({GRANT, PSEL, PENABLE, DONE} !== {exp, 4'b1_0_00}) begin
             n_bad++;
             $display("FAIL contention_grant[%0d]: got grant=%b psel=%b pen=%b done=%b, want %b 1 0 00",
                      k, GRANT, PSEL, PENABLE, DONE, exp);
           end
        1: if ({GRANT, PSEL, PENABLE, DONE} !== {exp, 4'b1_1_00}) begin
             n_bad++;
             $display("FAIL contention_access[%0d]: got grant=%b psel=%b pen=%b done=%b, want %b 1 1 00",
                      k, GRANT, PSEL, PENABLE, DONE, exp);
           end
        default: if ({DONE, GRANT, PSEL} !== {exp, 3'b00_0} || RDATA !== 32'h1234_5678) begin
             n_bad++;
             $display("FAIL contention_done[%0d]: got done=%b grant=%b psel=%b rdata=%h, want %b 00 0 12345678",
                      k, DONE, GRANT, PSEL, RDATA, exp);
           end
      endcase
    end
    REQ = 2'b00; PREADY = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    REQ = 2'b01; REQ_WRITE = 2'b01; REQ_ADDR = {32'h0, 32'h4}; REQ_WDATA = {32'h0, 32'h55}; PREADY = 1'b0;
    tick(); tick();
    for (int k = 2; k <= 16; k++) begin
      tick();
      n_cmp++;
      if ({DONE, PSEL, PENABLE} !== 4'b00_1_1) begin
        n_bad++;
        $display("FAIL timeout_wait[%0d]: got done=%b psel=%b pen=%b, want 00 1 1", k, DONE, PSEL, PENABLE);
      end
    end
    tick();
    n_cmp++;
    if ({DONE, ERR, PSEL, PENABLE, GRANT} !== 7'b01_1_0_0_00 || RDATA !== 32'h0) begin
      n_bad++;
      $display("FAIL timeout_abort: got done=%b err=%b psel=%b pen=%b grant=%b rdata=%h, want 01 1 0 0 00 0",
               DONE, ERR, PSEL, PENABLE, GRANT, RDATA);
    end
    REQ = 2'b00;
    tick();
    n_cmp++;
    if ({DONE, ERR} !== 3'b00_0) begin
      n_bad++;
      $display("FAIL timeout_pulse_end: got done=%b err=%b, want 00 0", DONE, ERR);
    end
  endtask

  task automatic test_reset_mid();
    REQ = 2'b01; REQ_WRITE = 2'b01; REQ_ADDR = {32'h0, 32'h2}; REQ_WDATA = {32'h0, 32'h77}; PREADY = 1'b0;
    tick(); tick();
    PRESET = 1'b1;
    tick();
    n_cmp++;
    if ({GRANT, DONE, ERR, PSEL, PENABLE, PWRITE} !== 8'b0 || PADDR !== 0 || PWDATA !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: got grant=%b done=%b err=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, want all zero",
               GRANT, DONE, ERR, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    PRESET = 1'b0; REQ = 2'b11; PREADY = 1'b1;
    tick();
    n_cmp++;
    if ({GRANT, PSEL, PENABLE} !== 4'b01_1_0) begin
      n_bad++;
      $display("FAIL reset_mid_first_grant: got grant=%b psel=%b pen=%b, want 01 1 0", GRANT, PSEL, PENABLE);
    end
    tick(); tick();
    n_cmp++;
    if (DONE !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_done: got done=%b, want 01", DONE);
    end
    REQ = 2'b00; PREADY = 1'b0;
    tick();
  endtask

  task automatic test_stale_pready();
    REQ = 2'b10; REQ_WRITE = 2'b10; REQ_ADDR = {32'h7, 32'h0}; REQ_WDATA = {32'hDEAD_BEEF, 32'h0}; PREADY = 1'b1;
    tick();
    n_cmp++;
    if ({GRANT, PSEL, PENABLE, DONE} !== 6'b10_1_0_00) begin
      n_bad++;
      $display("FAIL stale_setup: got grant=%b psel=%b pen=%b done=%b, want 10 1 0 00", GRANT, PSEL, PENABLE, DONE);
    end
    REQ_WDATA = {32'h0BAD_0BAD, 32'h0}; REQ_ADDR = {32'h3, 32'h0}; REQ_WRITE = 2'b00;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, DONE} !== 5'b1_1_1_00 || PWDATA !== 32'hDEAD_BEEF || PADDR !== 32'h7) begin
      n_bad++;
      $display("FAIL stale_access_stable: got psel=%b pen=%b pwr=%b done=%b pwdata=%h paddr=%h, want 1 1 1 00 deadbeef 7",
               PSEL, PENABLE, PWRITE, DONE, PWDATA, PADDR);
    end
    tick();
    n_cmp++;
    if ({DONE, ERR, PSEL} !== 4'b10_0_0) begin
      n_bad++;
      $display("FAIL stale_done: got done=%b err=%b psel=%b, want 10 0 0", DONE, ERR, PSEL);
    end
    REQ = 2'b00; PREADY = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_stale_pready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
